// File: rtl/calc_host_driver.sv
// Host-side initiator for the calculator operand/result port: drives A then B
// with a load strobe, releases the bus, waits WAIT_CYCLES, samples the result.
module calc_host_driver #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [7:0] i_req_a,
  input  logic [7:0] i_req_b,
  input  logic [3:0] i_req_op,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [7:0] o_rsp_y,
  output logic [3:0] o_rsp_op,
  output logic [7:0] o_bus_out,
  output logic [7:0] o_bus_oe,
  input  logic [7:0] i_bus_in,
  output logic [3:0] o_bus_sel,
  output logic       o_bus_stb,
  output logic       o_bus_addr,
  output logic [7:0] o_txn_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRV_A, S_DRV_B, S_TURN, S_WAIT, S_SAMPLE, S_RESP
  } state_t;

  localparam logic [3:0] W = 4'(WAIT_CYCLES);

  state_t     r_state, w_next;
  logic [7:0] r_b;
  logic [3:0] r_op;
  logic [3:0] r_wcnt;
  logic [7:0] r_bus_out, r_bus_oe;
  logic       r_bus_stb, r_bus_addr;
  logic [7:0] r_rsp_y;
  logic [3:0] r_rsp_op;
  logic [7:0] r_txn;
  logic       w_accept;
  logic       w_drv_next;

  assign o_req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_drv_next  = (w_next == S_DRV_A) || (w_next == S_DRV_B);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_DRV_A;
      S_DRV_A:  w_next = S_DRV_B;
      S_DRV_B:  w_next = S_TURN;
      S_TURN:   w_next = (W != 4'd0) ? S_WAIT : S_SAMPLE;
      S_WAIT:   if (r_wcnt <= 4'd1) w_next = S_SAMPLE;
      S_SAMPLE: w_next = S_RESP;
      S_RESP:   if (i_rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_b        <= 8'h00;
      r_op       <= 4'h0;
      r_wcnt     <= 4'h0;
      r_bus_out  <= 8'h00;
      r_bus_oe   <= 8'h00;
      r_bus_stb  <= 1'b0;
      r_bus_addr <= 1'b0;
      r_rsp_y    <= 8'h00;
      r_rsp_op   <= 4'h0;
      r_txn      <= 8'h00;
    end else begin
      r_state <= w_next;
      // Operand A goes straight into the bus register on accept, so only B is kept.
      if (w_accept) begin
        r_b  <= i_req_b;
        r_op <= i_req_op;
      end
      r_bus_oe  <= w_drv_next ? 8'hFF : 8'h00;
      r_bus_stb <= w_drv_next;
      if (w_next == S_DRV_A)      r_bus_out <= i_req_a;
      else if (w_next == S_DRV_B) r_bus_out <= r_b;
      else                        r_bus_out <= 8'h00;
      if (w_next == S_DRV_A)      r_bus_addr <= 1'b0;
      else if (w_next == S_DRV_B) r_bus_addr <= 1'b1;
      if (w_next == S_WAIT && r_state != S_WAIT) r_wcnt <= W;
      else if (r_state == S_WAIT && r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
      if (r_state == S_SAMPLE) begin
        r_rsp_y  <= i_bus_in;
        r_rsp_op <= r_op;
      end
      if (r_state == S_RESP && i_rsp_ready) r_txn <= r_txn + 8'd1;
    end
  end

  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_y     = r_rsp_y;
  assign o_rsp_op    = r_rsp_op;
  assign o_bus_out   = r_bus_out;
  assign o_bus_oe    = r_bus_oe;
  assign o_bus_sel   = r_op;
  assign o_bus_stb   = r_bus_stb;
  assign o_bus_addr  = r_bus_addr;
  assign o_txn_count = r_txn;

endmodule

// File: tb/tb_calc_host_driver.sv
// Directed bench for calc_host_driver: a W=2 instance and a W=0 instance,
// each hooked to a tiny calculator model that returns A+B when the bus is released.
module tb_calc_host_driver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] req_a, req_b;
  logic [3:0] req_op;
  int checks = 0;
  int errors = 0;

  // W=2 instance
  logic       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] rsp_y, bus_out, bus_oe, bus_in, txn;
  logic [3:0] rsp_op, bus_sel;
  logic       bus_stb, bus_addr;
  // W=0 instance
  logic       v0, rdy0, rv0, rr0;
  logic [7:0] y0, bo0, oe0, bi0, txn0;
  logic [3:0] op0, sel0;
  logic       stb0, addr0;

  calc_host_driver #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_y(rsp_y), .o_rsp_op(rsp_op),
    .o_bus_out(bus_out), .o_bus_oe(bus_oe), .i_bus_in(bus_in), .o_bus_sel(bus_sel),
    .o_bus_stb(bus_stb), .o_bus_addr(bus_addr), .o_txn_count(txn));

  calc_host_driver #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .i_req_valid(v0), .o_req_ready(rdy0),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op),
    .o_rsp_valid(rv0), .i_rsp_ready(rr0), .o_rsp_y(y0), .o_rsp_op(op0),
    .o_bus_out(bo0), .o_bus_oe(oe0), .i_bus_in(bi0), .o_bus_sel(sel0),
    .o_bus_stb(stb0), .o_bus_addr(addr0), .o_txn_count(txn0));

  // Calculator models: latch operands on strobe, present A+B when undriven.
  logic [7:0] m_a = 8'h00, m_b = 8'h00, m0_a = 8'h00, m0_b = 8'h00;
  logic [7:0] m_sum, m0_sum, ovr = 8'h00;
  logic       ovr_en = 1'b0;
  int stb_cnt = 0;
  always @(posedge clk) begin
    if (bus_stb) begin
      if (bus_addr) m_b <= bus_out; else m_a <= bus_out;
      stb_cnt <= stb_cnt + 1;
    end
    if (stb0) begin
      if (addr0) m0_b <= bo0; else m0_a <= bo0;
    end
  end
  assign m_sum  = m_a + m_b;
  assign m0_sum = m0_a + m0_b;
  assign bus_in = ovr_en ? ovr : ((bus_oe == 8'h00) ? m_sum : 8'h00);
  assign bi0    = (oe0 == 8'h00) ? m0_sum : 8'h00;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; v0 = 1'b0; rr0 = 1'b1;
    req_a = 8'h00; req_b = 8'h00; req_op = 4'h0;
    repeat (3) tick();
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b exp 0", req_ready); end
    checks++;
    if ({bus_oe, bus_out, bus_stb, bus_addr, bus_sel, rsp_valid, rsp_y, rsp_op, txn} !== 46'h0) begin
      errors++;
      $display("FAIL reset_values: oe=%h out=%h stb=%b addr=%b sel=%h rv=%b y=%h op=%h txn=%h exp all 0",
               bus_oe, bus_out, bus_stb, bus_addr, bus_sel, rsp_valid, rsp_y, rsp_op, txn);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b exp 1", req_ready); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    req_a = 8'h12; req_b = 8'h34; req_op = 4'h5; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    tick();
    checks++;
    if ({bus_stb, bus_addr, bus_out} !== {1'b1, 1'b1, 8'h34}) begin
      errors++; $display("FAIL mid_drv_b: stb=%b addr=%b out=%h exp 1 1 34", bus_stb, bus_addr, bus_out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({bus_oe, bus_stb, rsp_valid, txn, req_ready} !== {8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: oe=%h stb=%b rv=%b txn=%h rdy=%b exp 00 0 0 00 0",
               bus_oe, bus_stb, rsp_valid, txn, req_ready);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b exp 1", req_ready); end
    seen = 1'b0;
    repeat (10) begin tick(); if (rsp_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_dropped: rsp_valid seen=%b exp 0", seen); end
  endtask

  task automatic test_single;
    logic [7:0] e_oe, e_out;
    req_a = 8'h11; req_b = 8'h22; req_op = 4'h3; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      e_oe  = (k <= 2) ? 8'hFF : 8'h00;
      e_out = (k == 1) ? 8'h11 : (k == 2) ? 8'h22 : 8'h00;
      checks++;
      if ({bus_oe, bus_out, bus_stb, rsp_valid, bus_sel, req_ready} !==
          {e_oe, e_out, (k <= 2), (k == 7), 4'h3, 1'b0}) begin
        errors++;
        $display("FAIL single_cycle%0d: oe=%h out=%h stb=%b rv=%b sel=%h rdy=%b exp %h %h %b %b 3 0",
                 k, bus_oe, bus_out, bus_stb, rsp_valid, bus_sel, req_ready, e_oe, e_out, (k <= 2), (k == 7));
      end
      if (k <= 2) begin
        checks++;
        if (bus_addr !== (k == 2)) begin errors++; $display("FAIL single_addr%0d: got %b", k, bus_addr); end
      end
      if (k < 7) tick();
    end
    checks++;
    if ({rsp_y, rsp_op} !== {8'h33, 4'h3}) begin
      errors++; $display("FAIL single_result: y=%h op=%h exp 33 3", rsp_y, rsp_op);
    end
    rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, txn, req_ready} !== {1'b0, 8'h01, 1'b1}) begin
      errors++; $display("FAIL single_done: rv=%b txn=%h rdy=%b exp 0 01 1", rsp_valid, txn, req_ready);
    end
  endtask

  task automatic test_back_to_back;
    int n_acc, n_rsp, s0;
    int acc_c [2];
    logic [7:0] gy [2];
    logic [3:0] gop [2];
    logic acc, rsp;
    logic [7:0] t0;
    t0 = txn; s0 = stb_cnt; n_acc = 0; n_rsp = 0;
    acc_c[0] = 0; acc_c[1] = 0; gy[0] = 0; gy[1] = 0; gop[0] = 0; gop[1] = 0;
    req_a = 8'h05; req_b = 8'h07; req_op = 4'h1; req_valid = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 60 && n_rsp < 2; c++) begin
      acc = req_valid && req_ready;
      rsp = rsp_valid && rsp_ready;
      if (acc && n_acc < 2) begin acc_c[n_acc] = c; n_acc++; end
      if (rsp && n_rsp < 2) begin gy[n_rsp] = rsp_y; gop[n_rsp] = rsp_op; n_rsp++; end
      tick();
      if (acc && n_acc == 1) begin req_a = 8'h40; req_b = 8'h02; req_op = 4'h2; end
      if (acc && n_acc == 2) req_valid = 1'b0;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (n_rsp !== 2) begin errors++; $display("FAIL b2b_timeout: responses=%0d exp 2", n_rsp); end
    checks++;
    if (acc_c[1] - acc_c[0] !== 8) begin errors++; $display("FAIL b2b_period: got %0d exp 8", acc_c[1] - acc_c[0]); end
    checks++;
    if ({gy[0], gop[0], gy[1], gop[1]} !== {8'h0C, 4'h1, 8'h42, 4'h2}) begin
      errors++; $display("FAIL b2b_results: %h/%h %h/%h exp 0c/1 42/2", gy[0], gop[0], gy[1], gop[1]);
    end
    checks++;
    if (txn !== t0 + 8'd2) begin errors++; $display("FAIL b2b_txn: got %h exp %h", txn, t0 + 8'd2); end
    checks++;
    if (stb_cnt - s0 !== 4) begin errors++; $display("FAIL b2b_stb: got %0d exp 4", stb_cnt - s0); end
  endtask

  task automatic test_backpressure;
    logic seen;
    logic [7:0] t0;
    t0 = txn; seen = 1'b0;
    req_a = 8'h90; req_b = 8'h81; req_op = 4'hF; req_valid = 1'b1; rsp_ready = 1'b0;
    tick(); req_valid = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (rsp_valid) seen = 1'b1; else tick();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_timeout: rsp_valid never rose"); end
    ovr_en = 1'b1; ovr = 8'hAA;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({rsp_valid, rsp_y, rsp_op, req_ready, bus_oe, bus_stb} !== {1'b1, 8'h11, 4'hF, 1'b0, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: rv=%b y=%h op=%h rdy=%b oe=%h stb=%b exp 1 11 f 0 00 0",
                 k, rsp_valid, rsp_y, rsp_op, req_ready, bus_oe, bus_stb);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0; ovr_en = 1'b0;
    checks++;
    if ({rsp_valid, txn} !== {1'b0, t0 + 8'd1}) begin
      errors++; $display("FAIL bp_complete: rv=%b txn=%h exp 0 %h", rsp_valid, txn, t0 + 8'd1);
    end
  endtask

  task automatic test_w0;
    req_a = 8'h11; req_b = 8'h22; req_op = 4'h3; v0 = 1'b1;
    tick(); v0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if ({rv0, oe0} !== {(k == 5), (k <= 2) ? 8'hFF : 8'h00}) begin
        errors++; $display("FAIL w0_cycle%0d: rv=%b oe=%h", k, rv0, oe0);
      end
      if (k < 5) tick();
    end
    checks++;
    if ({y0, op0} !== {8'h33, 4'h3}) begin errors++; $display("FAIL w0_result: y=%h op=%h exp 33 3", y0, op0); end
    tick();
    checks++;
    if ({rv0, txn0, rdy0} !== {1'b0, 8'h01, 1'b1}) begin
      errors++; $display("FAIL w0_done: rv=%b txn=%h rdy=%b exp 0 01 1", rv0, txn0, rdy0);
    end
  endtask

  task automatic test_wrap;
    int n_acc, n_rsp, s0;
    logic acc;
    logic [7:0] last_y;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (txn !== 8'h00) begin errors++; $display("FAIL wrap_start: txn=%h exp 00", txn); end
    s0 = stb_cnt; n_acc = 0; n_rsp = 0; last_y = 8'h00;
    req_a = 8'h01; req_b = 8'h02; req_op = 4'h7; req_valid = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 256 * 9 + 20 && n_rsp < 256; c++) begin
      acc = req_valid && req_ready;
      if (acc) n_acc++;
      if (rsp_valid && rsp_ready) begin n_rsp++; last_y = rsp_y; end
      tick();
      if (acc && n_acc == 256) req_valid = 1'b0;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (n_rsp !== 256) begin errors++; $display("FAIL wrap_timeout: responses=%0d exp 256", n_rsp); end
    checks++;
    if (txn !== 8'h00) begin errors++; $display("FAIL wrap_txn: got %h exp 00", txn); end
    checks++;
    if (stb_cnt - s0 !== 512) begin errors++; $display("FAIL wrap_stb: got %0d exp 512", stb_cnt - s0); end
    checks++;
    if (last_y !== 8'h03) begin errors++; $display("FAIL wrap_last_y: got %h exp 03", last_y); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_w0();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_host_driver.md
# calc_host_driver

Host-side initiator for the calculator's 8-bit operand/result port. Accepts one operation request (operand A, operand B, 4-bit op select) over a valid/ready handshake and drives A, then B, onto the shared bidirectional data bus with a load strobe. It then releases the bus, waits a programmable settle time, samples the calculator's result and returns it over a valid/ready response channel. It sits on the tester/host side of the calculator's bidirectional data pins and its op-select inputs.

## Interface
- WAIT_CYCLES, 2: settle cycles between bus release and result sample; legal range 0..15.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request; equals (state == IDLE).
- req_a  in  8  operand A.
- req_b  in  8  operand B.
- req_op  in  4  ALU op select.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_y  out  8  sampled result.
- rsp_op  out  4  op of the returned result.
- bus_out  out  8  data driven to calculator.
- bus_oe  out  8  per-bit drive enable; 0xFF or 0x00 only.
- bus_in  in  8  data read from calculator.
- bus_sel  out  4  op select to calculator.
- bus_stb  out  1  operand load strobe.
- bus_addr  out  1  operand target: 0 = A, 1 = B.
- txn_count  out  8  completed transactions; wraps 0xFF→0x00.

## Operation
- States: IDLE, DRV_A, DRV_B, TURN, WAIT, SAMPLE, RESP.
- IDLE: bus_oe=0x00, bus_out=0x00, bus_stb=0. On req_valid && req_ready, latch req_a, req_b and req_op. Go to DRV_A.
- DRV_A: bus_oe=0xFF, bus_out=A, bus_stb=1, bus_addr=0. Next state DRV_B.
- DRV_B: bus_oe=0xFF, bus_out=B, bus_stb=1, bus_addr=1. Next state TURN.
- TURN: bus_oe=0x00, bus_out=0x00, bus_stb=0. One cycle in which nobody drives the bus. Next state WAIT if WAIT_CYCLES>0, else SAMPLE.
- WAIT: a down-counter loaded with WAIT_CYCLES on entry. Stay for exactly WAIT_CYCLES cycles, then go to SAMPLE.
- SAMPLE: bus released. On the exit edge, register bus_in into rsp_y and the latched op into rsp_op. Next state RESP.
- RESP: rsp_valid=1. rsp_y and rsp_op hold stable until rsp_valid && rsp_ready. On that edge, txn_count increments (mod 256) and the state returns to IDLE.
- bus_sel always reflects the latched op register. It changes only on request accept, so it is stable from DRV_A through SAMPLE.
- bus_addr holds its last value outside the DRV states. It is qualified by bus_stb.
- bus_oe and bus_out are registered outputs, decoded from the next state so they align with the state.

## Timing
- Reset values: state IDLE, bus_oe 0x00, bus_out 0x00, bus_stb 0, bus_addr 0, bus_sel 0x0, rsp_valid 0, rsp_y 0x00, rsp_op 0x0, txn_count 0x00, WAIT counter 0.
- While rst is high, req_ready=0 and requests are ignored. req_ready=1 in the first cycle after rst deasserts.
- Call the accepting edge E0. DRV_A occupies the cycle after E0, DRV_B the next, then TURN.
- SAMPLE is entered at edge E(3+W), where W=WAIT_CYCLES. bus_in is captured at E(4+W). rsp_valid is high from the cycle after E(4+W).
- Default W=2 gives rsp_valid in the 7th cycle after acceptance. Minimum W=0 gives the 5th cycle.
- bus_stb is high for exactly 2 consecutive cycles per transaction.
- The bus is never driven in the cycle immediately before SAMPLE, nor in SAMPLE itself.
- rsp_ready may be held high in advance. Under that condition the completion edge is E(5+W), and req_ready returns in the following cycle.
- Minimum transaction period is 6+W cycles. There is no overlap of request and response; req_ready=0 in all non-IDLE states.
- req_* inputs are ignored after acceptance. Changing them mid-transaction has no effect.
- Reset mid-transaction: at the next edge everything returns to reset values and the transaction is dropped. No rsp_valid is produced and txn_count is not incremented.
- rsp_valid asserted while rst rises: cleared at that edge and the result is lost.

## Test plan
- Single op, W=2: req a=0x11, b=0x22, op=0x3; bus model drives 0x33 on bus_in from TURN onward. Required: bus_out 0x11 then 0x22 with bus_stb high, then bus_oe=0x00; rsp_valid in cycle 7 with rsp_y=0x33, rsp_op=0x3; txn_count=1.
- Back-to-back: two requests with rsp_ready tied high and req_valid always high. Required: second accept exactly 6+W cycles after the first; both results are correct and in order; txn_count=2.
- Response backpressure: hold rsp_ready=0 for 10 cycles. Required: rsp_y stable, req_ready=0, and the bus stays released throughout; completion happens on the first rsp_ready=1 edge.
- W=0 build: same stimulus as the first scenario. Required: rsp_valid in cycle 5, and the TURN→SAMPLE transition occurs with no WAIT cycle.
- Reset mid-operation: assert rst during DRV_B. Required: at the next edge bus_oe=0x00, bus_stb=0, rsp_valid=0, txn_count unchanged; req_ready=1 one cycle after rst deasserts.
- Counter wrap: run 256 transactions. Required: txn_count reads 0x00 after the 256th completion, and bus_stb has pulsed 512 cycles in total.
